// File: rtl/serial_arith_pkg.sv
// -----------------------------------------------------------------------------
// serial_arith_pkg
// Shared types and helpers for the bit-serial arithmetic blocks.
//   state_e    : control FSM state encoding (IDLE, SHIFT, DONE), 2 bits
//   cnt_width  : bit width of a counter that must index WIDTH serial steps
// -----------------------------------------------------------------------------
package serial_arith_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Counter only has to reach WIDTH-1; never narrower than one bit.
  function automatic int cnt_width(input int width);
    int w;
    w = $clog2(width);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/serial_shift_reg.sv
// -----------------------------------------------------------------------------
// serial_shift_reg
// WIDTH-bit right-shift register with parallel load and serial input at the MSB.
// Ports:
//   clock_i     rising-edge clock
//   clr_i       synchronous active-high clear (highest priority)
//   load_i      parallel load of load_data_i (priority over shift)
//   load_data_i parallel load value
//   shift_i     shift right by one, serial_i enters at the MSB
//   serial_i    serial input bit
//   data_o      current register contents (bit 0 is the next bit out)
// -----------------------------------------------------------------------------
module serial_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clock_i,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_data_i,
  input  logic             shift_i,
  input  logic             serial_i,
  output logic [WIDTH-1:0] data_o
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (load_i) begin
      data_d = load_data_i;
    end else if (shift_i) begin
      data_d = {serial_i, data_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clock_i) begin
    if (clr_i) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/serial_addsub.sv
// -----------------------------------------------------------------------------
// serial_addsub
// Bit-serial two's-complement adder/subtractor. Operands load in parallel on a
// start request, then one bit pair per clock is summed LSB first through a
// single carry flop; each sum bit shifts back into the A register. After WIDTH
// shift cycles the result, final carry and signed overflow are registered and
// a one-cycle done pulse is issued.
//
// Optional build macro: SERIAL_ADDSUB_SAT_EN
//   defined   -> on signed overflow sum_out saturates toward the sign of A
//   undefined -> sum_out is the wrapped two's-complement result
//
// Ports:
//   clock      rising-edge clock
//   reset      synchronous active-high reset, clears all state
//   start      operation request, sampled only in IDLE
//   sub        0 = A+B, 1 = A-B, sampled with start
//   a_in/b_in  operands, sampled with start
//   busy       high while shifting
//   done       one-cycle pulse, result outputs valid
//   sum_out    registered result
//   carry_out  final carry (subtract: 1 = no borrow)
//   overflow   signed overflow of the operation
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | waiting for start; outputs hold the last result
// ST_SHIFT | one bit pair processed per clock, WIDTH cycles
// ST_DONE  | result registered, done pulse for one cycle
// -----------------------------------------------------------------------------
module serial_addsub
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_out,
  output logic             carry_out,
  output logic             overflow
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_MSB  = CW'(WIDTH - 2);

  state_e           state_q, state_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             c_msb_q, c_msb_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_out_q, carry_out_d;
  logic             ov_q, ov_d;
`ifdef SERIAL_ADDSUB_SAT_EN
  logic             sign_a_q, sign_a_d;
`endif

  logic             load;
  logic             shift;
  logic [WIDTH-1:0] b_load_val;
  logic [WIDTH-1:0] a_data;
  logic [WIDTH-1:0] b_data;
  logic             s_bit;
  logic             c_next;
  logic             ov_next;
  logic [WIDTH-1:0] raw_sum;
  logic             unused_b_hi;

  // Subtraction is A + ~B + 1: invert B at load, seed the carry with 1.
  assign b_load_val = sub ? ~b_in : b_in;

  serial_shift_reg #(.WIDTH(WIDTH)) u_a_reg (
    .clock_i     (clock),
    .clr_i       (reset),
    .load_i      (load),
    .load_data_i (a_in),
    .shift_i     (shift),
    .serial_i    (s_bit),
    .data_o      (a_data)
  );

  serial_shift_reg #(.WIDTH(WIDTH)) u_b_reg (
    .clock_i     (clock),
    .clr_i       (reset),
    .load_i      (load),
    .load_data_i (b_load_val),
    .shift_i     (shift),
    .serial_i    (1'b0),
    .data_o      (b_data)
  );

  // Only the LSB of B is consumed; the upper bits just shift through.
  assign unused_b_hi = ^b_data[WIDTH-1:1];

  assign s_bit   = a_data[0] ^ b_data[0] ^ carry_q;
  assign c_next  = (a_data[0] & b_data[0]) | (a_data[0] & carry_q) |
                   (b_data[0] & carry_q);
  // Signed overflow: carry into the MSB differs from carry out of it.
  assign ov_next = c_next ^ c_msb_q;
  // On the last step A still holds WIDTH-1 result bits above its LSB.
  assign raw_sum = {s_bit, a_data[WIDTH-1:1]};

  always_comb begin
    state_d     = state_q;
    carry_d     = carry_q;
    cnt_d       = cnt_q;
    c_msb_d     = c_msb_q;
    sum_d       = sum_q;
    carry_out_d = carry_out_q;
    ov_d        = ov_q;
`ifdef SERIAL_ADDSUB_SAT_EN
    sign_a_d    = sign_a_q;
`endif
    load        = 1'b0;
    shift       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          load     = 1'b1;
          carry_d  = sub;
          cnt_d    = '0;
`ifdef SERIAL_ADDSUB_SAT_EN
          sign_a_d = a_in[WIDTH-1];
`endif
          state_d  = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        shift   = 1'b1;
        carry_d = c_next;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CNT_MSB) begin
          c_msb_d = c_next;
        end
        if (cnt_q == CNT_LAST) begin
`ifdef SERIAL_ADDSUB_SAT_EN
          if (ov_next) begin
            sum_d = sign_a_q ? {1'b1, {(WIDTH-1){1'b0}}}
                             : {1'b0, {(WIDTH-1){1'b1}}};
          end else begin
            sum_d = raw_sum;
          end
`else
          sum_d = raw_sum;
`endif
          carry_out_d = c_next;
          ov_d        = ov_next;
          state_d     = ST_DONE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      c_msb_q     <= 1'b0;
      sum_q       <= '0;
      carry_out_q <= 1'b0;
      ov_q        <= 1'b0;
`ifdef SERIAL_ADDSUB_SAT_EN
      sign_a_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      carry_q     <= carry_d;
      cnt_q       <= cnt_d;
      c_msb_q     <= c_msb_d;
      sum_q       <= sum_d;
      carry_out_q <= carry_out_d;
      ov_q        <= ov_d;
`ifdef SERIAL_ADDSUB_SAT_EN
      sign_a_q    <= sign_a_d;
`endif
    end
  end

  assign busy      = (state_q == ST_SHIFT);
  assign done      = (state_q == ST_DONE);
  assign sum_out   = sum_q;
  assign carry_out = carry_out_q;
  assign overflow  = ov_q;

endmodule

// File: tb/tb_serial_addsub.sv
// -----------------------------------------------------------------------------
// tb_serial_addsub
// Directed self-checking bench for serial_addsub at WIDTH=8. Expected values
// are hand-computed constants; saturation expectations follow
// SERIAL_ADDSUB_SAT_EN.
// -----------------------------------------------------------------------------
module tb_serial_addsub;

  localparam int W = 8;

  logic         clock;
  logic         reset;
  logic         start;
  logic         sub;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         busy;
  logic         done;
  logic [W-1:0] sum_out;
  logic         carry_out;
  logic         overflow;

  int checks;
  int failures;

  serial_addsub #(.WIDTH(W)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .sub       (sub),
    .a_in      (a_in),
    .b_in      (b_in),
    .busy      (busy),
    .done      (done),
    .sum_out   (sum_out),
    .carry_out (carry_out),
    .overflow  (overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Start one operation and observe a fixed window of W+5 cycles after the
  // start edge. Optionally pulse start (with junk operands) at cycle pulse_at.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic s, input int pulse_at,
                       output int busy_n, output int done_n, output int done_at,
                       output logic [W-1:0] r_sum, output logic r_c,
                       output logic r_ov);
    busy_n  = 0;
    done_n  = 0;
    done_at = -1;
    r_sum   = 'x;
    r_c     = 1'bx;
    r_ov    = 1'bx;
    @(negedge clock);
    a_in  = a;
    b_in  = b;
    sub   = s;
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    a_in  = ~a;
    b_in  = b ^ 8'h5A;
    sub   = ~s;
    for (int i = 1; i <= W + 5; i++) begin
      @(negedge clock);
      if (busy) busy_n++;
      if (done) begin
        done_n++;
        done_at = i;
        r_sum   = sum_out;
        r_c     = carry_out;
        r_ov    = overflow;
      end
      if (i == pulse_at) begin
        start = 1'b1;
        a_in  = 8'h11;
        b_in  = 8'h22;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    start = 1'b1;
    sub   = 1'b0;
    a_in  = 8'h12;
    b_in  = 8'h34;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl: busy=%b done=%b required 0 0", busy, done);
    end
    checks++;
    if (sum_out !== 8'h00 || carry_out !== 1'b0 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: sum=%h c=%b ov=%b required 00 0 0",
               sum_out, carry_out, overflow);
    end
    reset = 1'b0;
    start = 1'b0;
    @(negedge clock);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_wins_start: busy=%b required 0", busy);
    end
  endtask

  task automatic test_add();
    int bn, dn, da;
    logic [W-1:0] rs;
    logic rc, rv;
    // 0x35 + 0x4A = 0x7F
    do_op(8'h35, 8'h4A, 1'b0, 0, bn, dn, da, rs, rc, rv);
    checks++;
    if (bn !== W) begin
      failures++;
      $display("FAIL add_busy_len: got %0d required %0d", bn, W);
    end
    checks++;
    if (dn !== 1 || da !== W + 1) begin
      failures++;
      $display("FAIL add_done_timing: count=%0d cycle=%0d required 1 %0d", dn, da, W + 1);
    end
    checks++;
    if (rs !== 8'h7F || rc !== 1'b0 || rv !== 1'b0) begin
      failures++;
      $display("FAIL add_basic: sum=%h c=%b ov=%b required 7f 0 0", rs, rc, rv);
    end
    // 0xFF + 0x01 wraps unsigned
    do_op(8'hFF, 8'h01, 1'b0, 0, bn, dn, da, rs, rc, rv);
    checks++;
    if (dn !== 1 || rs !== 8'h00 || rc !== 1'b1 || rv !== 1'b0) begin
      failures++;
      $display("FAIL add_wrap: done=%0d sum=%h c=%b ov=%b required 1 00 1 0",
               dn, rs, rc, rv);
    end
    // 0x7F + 0x01 signed overflow
    do_op(8'h7F, 8'h01, 1'b0, 0, bn, dn, da, rs, rc, rv);
    checks++;
`ifdef SERIAL_ADDSUB_SAT_EN
    if (rs !== 8'h7F || rc !== 1'b0 || rv !== 1'b1) begin
      failures++;
      $display("FAIL add_ovf: sum=%h c=%b ov=%b required 7f 0 1", rs, rc, rv);
    end
`else
    if (rs !== 8'h80 || rc !== 1'b0 || rv !== 1'b1) begin
      failures++;
      $display("FAIL add_ovf: sum=%h c=%b ov=%b required 80 0 1", rs, rc, rv);
    end
`endif
  endtask

  task automatic test_sub();
    int bn, dn, da;
    logic [W-1:0] rs;
    logic rc, rv;
    // 0x10 - 0x20 borrows
    do_op(8'h10, 8'h20, 1'b1, 0, bn, dn, da, rs, rc, rv);
    checks++;
    if (bn !== W || dn !== 1 || da !== W + 1) begin
      failures++;
      $display("FAIL sub_timing: busy=%0d done=%0d at %0d", bn, dn, da);
    end
    checks++;
    if (rs !== 8'hF0 || rc !== 1'b0 || rv !== 1'b0) begin
      failures++;
      $display("FAIL sub_borrow: sum=%h c=%b ov=%b required f0 0 0", rs, rc, rv);
    end
    // 0x80 - 0x01 negative overflow
    do_op(8'h80, 8'h01, 1'b1, 0, bn, dn, da, rs, rc, rv);
    checks++;
`ifdef SERIAL_ADDSUB_SAT_EN
    if (rs !== 8'h80 || rc !== 1'b1 || rv !== 1'b1) begin
      failures++;
      $display("FAIL sub_ovf: sum=%h c=%b ov=%b required 80 1 1", rs, rc, rv);
    end
`else
    if (rs !== 8'h7F || rc !== 1'b1 || rv !== 1'b1) begin
      failures++;
      $display("FAIL sub_ovf: sum=%h c=%b ov=%b required 7f 1 1", rs, rc, rv);
    end
`endif
    // 0x05 - 0x05 = 0, no borrow
    do_op(8'h05, 8'h05, 1'b1, 0, bn, dn, da, rs, rc, rv);
    checks++;
    if (rs !== 8'h00 || rc !== 1'b1 || rv !== 1'b0) begin
      failures++;
      $display("FAIL sub_equal: sum=%h c=%b ov=%b required 00 1 0", rs, rc, rv);
    end
  endtask

  task automatic test_ignore_start();
    int bn, dn, da;
    logic [W-1:0] rs;
    logic rc, rv;
    // 0x23 + 0x41 = 0x64, with a stray start in the third shift cycle
    do_op(8'h23, 8'h41, 1'b0, 3, bn, dn, da, rs, rc, rv);
    checks++;
    if (bn !== W || dn !== 1 || da !== W + 1) begin
      failures++;
      $display("FAIL ignore_start_timing: busy=%0d done=%0d at %0d required %0d 1 %0d",
               bn, dn, da, W, W + 1);
    end
    checks++;
    if (rs !== 8'h64 || rc !== 1'b0 || rv !== 1'b0) begin
      failures++;
      $display("FAIL ignore_start_result: sum=%h c=%b ov=%b required 64 0 0", rs, rc, rv);
    end
  endtask

  task automatic test_back_to_back();
    int bn, dn, da;
    int held_bad;
    int got_done;
    logic [W-1:0] rs;
    logic rc, rv;
    // 0xC0 + 0x50 = 0x110 -> 0x10 carry 1
    do_op(8'hC0, 8'h50, 1'b0, 0, bn, dn, da, rs, rc, rv);
    checks++;
    if (rs !== 8'h10 || rc !== 1'b1 || rv !== 1'b0) begin
      failures++;
      $display("FAIL b2b_first: sum=%h c=%b ov=%b required 10 1 0", rs, rc, rv);
    end
    // Second op 0x01 + 0x02: previous result must hold while shifting.
    @(negedge clock);
    a_in  = 8'h01;
    b_in  = 8'h02;
    sub   = 1'b0;
    start = 1'b1;
    @(posedge clock);
    #1;
    start    = 1'b0;
    held_bad = 0;
    got_done = 0;
    for (int i = 1; i <= W + 3; i++) begin
      @(negedge clock);
      if (busy && (sum_out !== 8'h10 || carry_out !== 1'b1 || overflow !== 1'b0))
        held_bad++;
      if (done) begin
        got_done++;
        rs = sum_out;
        rc = carry_out;
        rv = overflow;
      end
    end
    checks++;
    if (held_bad !== 0) begin
      failures++;
      $display("FAIL b2b_hold: %0d cycles with changed outputs, required 0", held_bad);
    end
    checks++;
    if (got_done !== 1 || rs !== 8'h03 || rc !== 1'b0 || rv !== 1'b0) begin
      failures++;
      $display("FAIL b2b_second: done=%0d sum=%h c=%b ov=%b required 1 03 0 0",
               got_done, rs, rc, rv);
    end
  endtask

  task automatic test_reset_abort();
    int bn, dn, da;
    int seen_done;
    logic [W-1:0] rs;
    logic rc, rv;
    // Leave a nonzero result in the outputs first: 0xF0 + 0x20 = 0x10, carry 1
    do_op(8'hF0, 8'h20, 1'b0, 0, bn, dn, da, rs, rc, rv);
    @(negedge clock);
    a_in  = 8'h35;
    b_in  = 8'h4A;
    sub   = 1'b0;
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (4) @(negedge clock);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL abort_busy: busy=%b required 1 in shift cycle 4", busy);
    end
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || sum_out !== 8'h00 ||
        carry_out !== 1'b0 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL abort_outputs: busy=%b done=%b sum=%h c=%b ov=%b required 0 0 00 0 0",
               busy, done, sum_out, carry_out, overflow);
    end
    reset     = 1'b0;
    seen_done = 0;
    for (int i = 0; i < W + 4; i++) begin
      @(negedge clock);
      if (done || busy) seen_done++;
    end
    checks++;
    if (seen_done !== 0) begin
      failures++;
      $display("FAIL abort_no_done: %0d active cycles after abort, required 0", seen_done);
    end
    // 0x35 + 0x4A after abort completes normally
    do_op(8'h35, 8'h4A, 1'b0, 0, bn, dn, da, rs, rc, rv);
    checks++;
    if (bn !== W || dn !== 1 || da !== W + 1 || rs !== 8'h7F || rc !== 1'b0 || rv !== 1'b0) begin
      failures++;
      $display("FAIL abort_recover: busy=%0d done=%0d at %0d sum=%h c=%b ov=%b required %0d 1 %0d 7f 0 0",
               bn, dn, da, rs, rc, rv, W, W + 1);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    start    = 1'b0;
    sub      = 1'b0;
    a_in     = '0;
    b_in     = '0;
    test_reset();
    test_add();
    test_sub();
    test_ignore_start();
    test_back_to_back();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_addsub.md
Name: serial_addsub

Overview:
- Parametrised bit-serial two's-complement adder/subtractor.
- Operands load in parallel, then one bit pair is processed per clock, LSB first, through a single carry flop. Each sum bit shifts back into the A operand register.
- Start/busy/done handshake with registered result, carry and signed-overflow flags.
- Next-generation serial arithmetic unit of the datapath library: arbitrary width, subtract mode, completion handshake.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..64.

Ports:
- clock      input   1      rising-edge clock, single domain
- reset      input   1      synchronous, active-high; clears all state
- start      input   1      request; sampled only in IDLE
- sub        input   1      0 = A+B, 1 = A-B; sampled with start
- a_in       input   WIDTH  operand A; sampled with start
- b_in       input   WIDTH  operand B; sampled with start
- busy       output  1      high while in SHIFT
- done       output  1      one-cycle pulse; result valid
- sum_out    output  WIDTH  registered result
- carry_out  output  1      final carry; in sub mode 1 = no borrow (A >= B unsigned)
- overflow   output  1      signed overflow of the operation

Behaviour:
- Reset is synchronous, active-high, one clock domain. On reset: state=IDLE; busy=0, done=0, sum_out=0, carry_out=0, overflow=0; shift registers, carry flop and counter cleared.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 at an edge: load A_reg=a_in; load B_reg=b_in, or ~b_in if sub=1.
  - carry flop = sub; bit counter = 0; capture sign_a = a_in[WIDTH-1].
  - Next state SHIFT.
- SHIFT, each edge:
  - s = A_reg[0]^B_reg[0]^c; c_next = majority(A_reg[0],B_reg[0],c).
  - A_reg = {s, A_reg[WIDTH-1:1]}; B_reg shifts right, zero fill.
  - count increments.
  - On the edge with count = WIDTH-2, record c_msb_in = c_next.
  - On the edge with count = WIDTH-1 (the last bit):
    - sum_out = {s, A_reg[WIDTH-1:1]}
    - carry_out = c_next
    - overflow = c_next ^ c_msb_in
    - next state DONE.
  - SHIFT therefore lasts exactly WIDTH cycles.
- DONE: done=1 for exactly one cycle, then IDLE.
- Latency: start sampled at edge k -> busy high during cycles k+1..k+WIDTH -> done high in cycle k+WIDTH+1.
- start while in SHIFT or DONE is ignored; there is no queueing. Operand changes after the start edge have no effect.
- sum_out, carry_out and overflow hold their values until the next DONE entry or reset; they do not change when a new operation starts.
- reset asserted mid-SHIFT: the operation is aborted, there is no done pulse, and all outputs go to reset values on that edge.
- reset and start on the same edge: reset wins.
- Counter width is $clog2(WIDTH).

Optional Feature:
- Macro SERIAL_ADDSUB_SAT_EN.
- Defined: when overflow=1, sum_out is saturated.
  - sign_a=0 -> {0,{WIDTH-1{1}}} (most positive value).
  - sign_a=1 -> {1,{WIDTH-1{0}}} (most negative value).
  - overflow flag and carry_out are still reported unchanged.
- Undefined: sum_out is the wrapped two's-complement result. No saturation logic is synthesised.

Decomposition:
- Package serial_arith_pkg holds:
  - state enum (IDLE, SHIFT, DONE), 2 bits;
  - localparam helper for counter width.
- Sub-module serial_shift_reg (WIDTH, parallel load, serial-in at MSB, shift enable, synchronous active-high clear), instantiated twice: once for A/result with serial-in s, once for B with serial-in 0.
- Carry flop, counter and FSM stay in the top module.

Test Plan (WIDTH=8):
- Add, no carry: start, sub=0, a=0x35, b=0x4A -> busy exactly 8 cycles; done in cycle 9 after start; sum=0x7F, carry=0, ov=0.
- Unsigned wrap: a=0xFF, b=0x01, add -> sum=0x00, carry=1, ov=0.
- Signed overflow: a=0x7F, b=0x01, add -> sum=0x80, ov=1, carry=0. With SERIAL_ADDSUB_SAT_EN defined -> sum=0x7F, ov=1.
- Subtract with borrow: a=0x10, b=0x20, sub=1 -> sum=0xF0, carry=0, ov=0.
- Subtract, negative overflow: a=0x80, b=0x01, sub=1 -> sum=0x7F, ov=1, carry=1. With SERIAL_ADDSUB_SAT_EN defined -> sum=0x80.
- Control corners:
  - start pulsed again during SHIFT -> ignored, single done.
  - reset at 4th SHIFT cycle -> no done; outputs 0; the next start completes normally.
